// File: rtl/iob_sp_ram_ctrl_if.sv
// Host request/response and single-port RAM signals of iob_sp_ram_ctrl.
// The slave view belongs to the controller; the master view is the host plus RAM side.
interface iob_sp_ram_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
);
   logic              req_valid;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              init_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
      input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_din, init_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
      output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_din, init_done
   );
endinterface

// File: rtl/iob_sp_ram_ctrl.sv
// Single-port RAM controller: host request/response front end with 1-cycle read latency.
// Define IOB_SP_RAM_CTRL_CLEAR_EN to zero the whole RAM after every reset before serving the host.
module iob_sp_ram_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input logic                clk,
   input logic                reset,
   iob_sp_ram_ctrl_if.slave   bus
);

`ifdef IOB_SP_RAM_CTRL_CLEAR_EN
   typedef enum logic [0:0] {CLEAR, IDLE} state_t;
   localparam state_t ST_RST = CLEAR;
`else
   typedef enum logic [0:0] {IDLE} state_t;
   localparam state_t ST_RST = IDLE;
`endif

   state_t            state, state_nxt;
   logic              stall;
   logic              req_ready;
   logic              rd_acc;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic              rsp_vld_p1;
   logic              rd_vld_p1;
   logic [DATA_W-1:0] rsp_data_p1;

`ifdef IOB_SP_RAM_CTRL_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         clr_cnt <= '0;
      else if (state == CLEAR)
         clr_cnt <= clr_cnt + ADDR_W'(1);
   end
`endif

   assign stall  = rsp_vld_p1 & ~bus.rsp_ready;
   assign rd_acc = bus.req_valid & req_ready & ~bus.req_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_RST;
      else
         state <= state_nxt;
   end

   // Reset gates both acceptance and the RAM enable so nothing reaches memory while it is held.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = bus.req_addr;
      mem_din   = bus.req_wdata;
      case (state)
`ifdef IOB_SP_RAM_CTRL_CLEAR_EN
         CLEAR: begin
            mem_en   = ~reset;
            mem_we   = 1'b1;
            mem_addr = clr_cnt;
            mem_din  = '0;
            if (clr_cnt == '1)
               state_nxt = IDLE;
         end
`endif
         IDLE: begin
            req_ready = ~stall & ~reset;
            mem_en    = bus.req_valid & req_ready;
            mem_we    = bus.req_we;
         end
         default: ;
      endcase
   end

   // Stage 1: RAM output is live for one cycle after a read, then a local copy holds it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_vld_p1 <= 1'b0;
         rd_vld_p1  <= 1'b0;
      end else begin
         rsp_vld_p1 <= rd_acc | stall;
         rd_vld_p1  <= rd_acc;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_vld_p1)
         rsp_data_p1 <= bus.mem_dout;
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_vld_p1;
   assign bus.rsp_rdata = rd_vld_p1 ? bus.mem_dout : rsp_data_p1;
   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_din   = mem_din;
   assign bus.init_done = (state == IDLE);

endmodule

// File: tb/tb_iob_sp_ram_ctrl.sv
// Directed bench for iob_sp_ram_ctrl with a behavioural registered-output single-port RAM.
// Works with and without IOB_SP_RAM_CTRL_CLEAR_EN defined.
module tb_iob_sp_ram_ctrl;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
`ifdef IOB_SP_RAM_CTRL_CLEAR_EN
   localparam logic INIT_RST = 1'b0;
`else
   localparam logic INIT_RST = 1'b1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   iob_sp_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   iob_sp_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Read-first RAM with registered output; non-zero power-up contents expose a missing clear.
   logic [DATA_W-1:0] ram [DEPTH] = '{default: 16'hFFFF};
   logic [DATA_W-1:0] dout_r = 16'hFFFF;

   assign bus.mem_dout = dout_r;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we)
            ram[bus.mem_addr] <= bus.mem_din;
         dout_r <= ram[bus.mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
   endtask

`ifdef IOB_SP_RAM_CTRL_CLEAR_EN
   task automatic sweep(input int n);
      for (int i = 0; i < n; i++) begin
         chk("clr_cycle",
             32'({bus.mem_en, bus.mem_we, bus.init_done, bus.req_ready, bus.mem_addr, bus.mem_din}),
             32'({4'b1100, 5'(i), 16'h0000}));
         @(negedge clk);
      end
   endtask
`endif

   logic [DATA_W-1:0] exp_rd [3] = '{16'h0011, 16'h0022, 16'h0033};

   initial begin
      drive(1'b0, 1'b0, '0, '0);
      bus.rsp_ready = 1'b0;
      #3;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
      chk("rst_init_done", 32'(bus.init_done), 32'(INIT_RST));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;

`ifdef IOB_SP_RAM_CTRL_CLEAR_EN
      sweep(DEPTH);
      chk("clr_done", 32'({bus.init_done, bus.req_ready}), 32'b11);
      bus.rsp_ready = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         if (i > 0)
            chk("clr_readback", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'({1'b1, 16'h0000}));
         if (i < DEPTH) drive(1'b1, 1'b0, 5'(i), '0);
         else           drive(1'b0, 1'b0, '0, '0);
         @(negedge clk);
      end
`else
      chk("norst_ready", 32'({bus.init_done, bus.req_ready, bus.mem_en}), 32'b110);
      @(negedge clk);
      chk("norst_no_write", 32'(bus.mem_en), 32'd0);
`endif

      // write then read of the same address on the following edge
      bus.rsp_ready = 1'b1;
      drive(1'b1, 1'b1, 5'd7, 16'hA5A5);
      #1;
      chk("wr_strobe", 32'({bus.req_ready, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din}),
          32'({3'b111, 5'd7, 16'hA5A5}));
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd7, '0);
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
      chk("raw_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'({1'b1, 16'hA5A5}));
      @(negedge clk);
      chk("rsp_consumed", 32'(bus.rsp_valid), 32'd0);

      // three writes, then three back-to-back reads
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, 1'b1, 5'(k), exp_rd[k-1]);
         @(negedge clk);
      end
      for (int k = 0; k <= 3; k++) begin
         if (k > 0)
            chk("b2b_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'({1'b1, exp_rd[k-1]}));
         if (k < 3) begin
            drive(1'b1, 1'b0, 5'(k + 1), '0);
            #1;
            chk("b2b_ready", 32'(bus.req_ready), 32'd1);
         end else begin
            drive(1'b0, 1'b0, '0, '0);
         end
         @(negedge clk);
      end
      chk("b2b_drained", 32'(bus.rsp_valid), 32'd0);

      // write accepted on the edge that consumes a pending response
      bus.rsp_ready = 1'b0;
      drive(1'b1, 1'b0, 5'd3, '0);
      @(negedge clk);
      chk("pend_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'({1'b1, 16'h0033}));
      bus.rsp_ready = 1'b1;
      drive(1'b1, 1'b1, 5'd4, 16'h5555);
      #1;
      chk("wr_on_consume_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
      chk("wr_on_consume", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'({1'b0, 16'h0033}));

      // stalled response held for five cycles while the host keeps requesting
      drive(1'b1, 1'b1, 5'd4, 16'h1234);
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd4, '0);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         drive(1'b1, 1'b0, 5'd2, '0);
         #1;
         chk("stall_hold", 32'({bus.rsp_valid, bus.req_ready, bus.mem_en, bus.rsp_rdata}),
             32'({3'b100, 16'h1234}));
         @(negedge clk);
      end
      drive(1'b0, 1'b0, '0, '0);
      bus.rsp_ready = 1'b1;
      #1;
      chk("stall_release", 32'({bus.rsp_valid, bus.req_ready}), 32'b11);
      @(negedge clk);
      chk("stall_consumed", 32'(bus.rsp_valid), 32'd0);

      // asynchronous reset discards a pending response
      bus.rsp_ready = 1'b0;
      drive(1'b1, 1'b0, 5'd2, '0);
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
      chk("pre_rst_rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 32'({1'b1, 16'h0022}));
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst", 32'({bus.rsp_valid, bus.mem_en, bus.init_done}), 32'({2'b00, INIT_RST}));
      @(negedge clk);
      reset = 1'b0;
      bus.rsp_ready = 1'b1;
      #1;

`ifdef IOB_SP_RAM_CTRL_CLEAR_EN
      sweep(10);
      chk("clr_at10", 32'(bus.mem_addr), 32'd10);
      #2;
      reset = 1'b1;
      #1;
      chk("clr_abort", 32'({bus.rsp_valid, bus.init_done, bus.mem_en}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      sweep(DEPTH);
      chk("clr_redone", 32'({bus.init_done, bus.req_ready}), 32'b11);
`else
      chk("post_rst_ready", 32'({bus.init_done, bus.req_ready, bus.rsp_valid}), 32'b110);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/iob_sp_ram_ctrl.md
IOB_SP_RAM_CTRL -- requirements
Module: iob_sp_ram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, data width of host and memory sides.
REQ-002 Parameter ADDR_W, default 5, address width; memory depth 2**ADDR_W words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  ADDR_W  host word address.
REQ-008 req_wdata  input  DATA_W  host write data.
REQ-009 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-010 rsp_valid  output  1  read data available.
REQ-011 rsp_rdata  output  DATA_W  read data.
REQ-012 rsp_ready  input  1  host consumes response when high with rsp_valid.
REQ-013 mem_en, mem_we  output  1 each  enable and write strobe to the single-port RAM.
REQ-014 mem_addr  output  ADDR_W; mem_din  output  DATA_W  RAM address and write data.
REQ-015 mem_dout  input  DATA_W  RAM read data, registered, valid one cycle after a read enable.
REQ-016 init_done  output  1  high when the controller accepts host requests.

Function
REQ-017 FSM states: CLEAR, IDLE; CLEAR exists only under the configuration macro.
REQ-018 Stall term: stall = rsp_valid & ~rsp_ready.
REQ-019 req_ready = (state==IDLE) & ~stall, combinational.
REQ-020 In IDLE: mem_en = req_valid & req_ready; mem_we = req_we; mem_addr = req_addr; mem_din = req_wdata.
REQ-021 Read accepted at edge N: rsp_valid high from N+1, rsp_rdata = mem_dout; read latency exactly 1 cycle.
REQ-022 rsp_valid clears at the edge where rsp_valid & rsp_ready, unless a new read is accepted at that same edge, in which case it stays high.
REQ-023 Back-to-back reads with rsp_ready held high: one read accepted per cycle, one response per cycle, in order.
REQ-024 While stall: req_ready low, mem_en low, rsp_rdata held stable (RAM not re-enabled, so mem_dout unchanged).
REQ-025 Writes produce no response; a write accepted in the same cycle a response is consumed does not alter rsp_rdata.
REQ-026 Write at edge N followed by read of same address at edge N+1 returns the new data at N+2.
REQ-027 A write accepted at the edge where rsp_valid & rsp_ready clears rsp_valid.

Reset
REQ-028 On reset assertion, immediately: rsp_valid=0, clear counter=0, state=CLEAR (macro defined) or IDLE (undefined).
REQ-029 init_done reset value: 0 with macro, 1 without; mem_en low while reset is high.
REQ-030 Reset asserted mid-clear restarts the sweep from address 0 after deassertion; pending response is discarded.

Configuration
REQ-031 Macro IOB_SP_RAM_CTRL_CLEAR_EN: when defined, after reset the controller stays in CLEAR for exactly 2**ADDR_W cycles writing 0 to addresses 0 to 2**ADDR_W-1 in ascending order (mem_en=1, mem_we=1, mem_din=0, mem_addr=counter).
REQ-032 With macro defined: req_ready=0 and init_done=0 during CLEAR; on the cycle after address 2**ADDR_W-1 is written, state=IDLE and init_done=1; counter wraps without overflow side effects.
REQ-033 Without macro: no CLEAR state or counter logic; IDLE and init_done=1 from reset; RAM contents undefined until written.

Verification
REQ-034 Macro defined, reset release -> 32 consecutive cycles mem_we=1, mem_addr 0..31, mem_din=0; init_done rises on cycle 33; then reads of addresses 0..31 all return 0x0000.
REQ-035 Write 0xA5A5 to address 7, next cycle read address 7, rsp_ready=1 -> rsp_valid one cycle after read accept, rsp_rdata=0xA5A5.
REQ-036 Reads of addresses 1,2,3 in consecutive cycles after writing 0x0011,0x0022,0x0033 -> responses in three consecutive cycles, in order.
REQ-037 Read of address 4 (data 0x1234) with rsp_ready=0 for 5 cycles -> rsp_valid high, rsp_rdata=0x1234 stable, req_ready=0, mem_en=0 throughout; response consumed on the cycle rsp_ready goes high.
REQ-038 Reset asserted at clear address 10 -> rsp_valid=0 and init_done=0 at once; sweep restarts at address 0 after release.
REQ-039 Macro undefined -> init_done=1 and req_ready=1 (given no stall) in the first cycle after reset release; no writes issued without host requests.
